// File: rtl/mixer_pkg.sv
// mixer_pkg: shared sizing, clipping and range helpers for the mixer and formatter blocks
//   sum_w    : full-precision width of an n_ch-input sum of in_w-bit samples
//   max_val  : largest signed value representable in w bits
//   min_val  : smallest signed value representable in w bits
//   sat_clip : clamp a signed value into w bits, flagging when clamping occurred
package mixer_pkg;
  typedef struct packed {
    logic signed [31:0] val;
    logic               clip;
  } clip_t;
  function automatic int sum_w(input int n_ch, input int in_w);
    return in_w + $clog2(n_ch);
  endfunction
  function automatic logic signed [31:0] max_val(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction
  function automatic logic signed [31:0] min_val(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction
  function automatic clip_t sat_clip(input logic signed [31:0] v, input int w);
    clip_t c;
    c.clip = (v > max_val(w)) || (v < min_val(w));
    c.val  = v > max_val(w) ? max_val(w) : v < min_val(w) ? min_val(w) : v;
    return c;
  endfunction
endpackage

// File: rtl/mixer_adder_tree.sv
// mixer_adder_tree: combinational signed sum of N_CH operands of SUM_W bits
//   ops : packed operands, operand k at [k*SUM_W +: SUM_W]
//   sum : signed total; SUM_W already covers growth so it cannot overflow
module mixer_adder_tree #(
  parameter int N_CH  = 4,
  parameter int SUM_W = 10
) (
  input  logic [N_CH*SUM_W-1:0]  ops,
  output logic signed [SUM_W-1:0] sum
);
  always_comb begin
    sum = '0;
    for (int k = 0; k < N_CH; k++) sum = sum + $signed(ops[k*SUM_W +: SUM_W]);
  end
endmodule

// File: rtl/signal_mixer.sv
// signal_mixer: N-channel signed mixer with mute, averaging, saturation and a 2-stage valid/ready pipeline
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready, mute, avg_en : input sample handshake with per-sample controls
//   out_data/out_valid/out_ready            : saturated output handshake
//   sat_flag, clr_sat    : sticky clip indicator and its synchronous clear (set wins)
module signal_mixer
  import mixer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int IN_W  = 8,
  parameter int OUT_W = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*IN_W-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_CH-1:0]        mute,
  input  logic                   avg_en,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sat_flag,
  input  logic                   clr_sat
);
  localparam int SUM_W = sum_w(N_CH, IN_W);
  localparam int LOG_N = $clog2(N_CH);
  logic [N_CH*SUM_W-1:0]   s1_data_q, s1_data_d;
  logic                    s1_avg_q, s1_avg_d, s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d, sat_q, sat_d;
  logic                    s1_adv, acc, s2_load;
  logic signed [SUM_W-1:0] sum, r;
  clip_t                   c;
  mixer_adder_tree #(.N_CH(N_CH), .SUM_W(SUM_W)) u_tree (.ops(s1_data_q), .sum(sum));
  always_comb begin
    s1_adv   = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s1_adv;
    acc      = in_valid && in_ready;
    s2_load  = s1_valid_q && s1_adv;
    s1_data_d = s1_data_q;
    for (int k = 0; k < N_CH; k++)
      if (acc) s1_data_d[k*SUM_W +: SUM_W] = mute[k] ? '0 : SUM_W'($signed(in_data[k*IN_W +: IN_W]));
    s1_avg_d    = acc ? avg_en : s1_avg_q;
    s1_valid_d  = acc || (s1_valid_q && !s1_adv);
    r           = s1_avg_q ? sum >>> LOG_N : sum;
    c           = sat_clip(32'(r), OUT_W);
    out_data_d  = s2_load ? OUT_W'(c.val) : out_data_q;
    out_valid_d = s2_load || (out_valid_q && !out_ready);
    sat_d       = (s2_load && c.clip) || (sat_q && !clr_sat);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q   <= '0;
      s1_avg_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      s1_data_q   <= s1_data_d;
      s1_avg_q    <= s1_avg_d;
      s1_valid_q  <= s1_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sat_q       <= sat_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_q;
endmodule

// File: doc/signal_mixer.md
Name: signal_mixer

Overview:
Parametrised N-channel signed signal mixer. It is the successor to the two-input registered wave adder.
- Sums N_CH two's-complement channel samples.
- Optional per-channel mute and averaging mode.
- Saturates to OUT_W with a sticky overflow flag.
- Uses a 2-stage valid/ready pipeline with full backpressure, so it can sit between a wave generator bank and the DAC/output formatter.

Parameters:
N_CH, 4, number of input channels; power of two, 2..16.
IN_W, 8, per-channel sample width, signed.
OUT_W, 9, output width, signed; IN_W <= OUT_W <= SUM_W.
(derived, localparam) SUM_W = IN_W + $clog2(N_CH), full-precision sum width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  N_CH*IN_W  packed channel samples; channel k at bits [k*IN_W +: IN_W].
in_valid  in  1  in_data valid.
in_ready  out  1  mixer can accept a sample this cycle.
mute  in  N_CH  per-channel mute; 1 forces that channel to 0. Sampled with in_data on accept.
avg_en  in  1  1 selects output = sum >>> log2(N_CH). Sampled on accept.
out_data  out  OUT_W  mixed sample, signed.
out_valid  out  1  out_data valid.
out_ready  in  1  downstream accepts.
sat_flag  out  1  sticky: set when any output sample was clipped.
clr_sat  in  1  synchronous clear of sat_flag.

Behaviour:
- Interface: clock clk, reset rst_n (asynchronous, active-low).
- Reset values:
  - out_valid=0, out_data=0, sat_flag=0.
  - All stage registers and valid bits cleared.
  - in_ready=1 after reset, since it is combinational from the empty pipeline.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_data/mute/avg_en are ignored when no transfer occurs.
- Stage 1 (S1):
  - On accept, registers the masked channel samples, each sign-extended to SUM_W, together with avg_en.
  - Sets s1_valid.
- Stage 2 (S2):
  - Loads from S1 when s1_valid && (!out_valid || out_ready).
  - The load computes the full-precision signed sum of the S1 channels, width SUM_W; it can never overflow internally.
  - If the S1 avg_en was set: r = sum >>> log2(N_CH), an arithmetic shift that floors toward minus infinity. Otherwise r = sum.
  - Saturation: if r > 2^(OUT_W-1)-1, out_data = max; if r < -2^(OUT_W-1), out_data = min; otherwise out_data = r truncated to OUT_W.
  - Sets out_valid.
- Advance rules:
  - s1_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s1_adv.
  - Stages hold their contents when stalled.
  - Bubbles are collapsed: S1 may fill while S2 holds a stalled output.
- Latency and throughput: 2 cycles from accept to out_valid. Throughput is 1 sample/cycle with out_ready held high.
- Ordering: strictly in order; no sample is dropped or duplicated under any stall pattern.
- Output clearing: if S2 is not reloaded on an output transfer cycle, out_valid clears.
- sat_flag:
  - Set on the cycle S2 loads a clipped value.
  - Cleared by clr_sat.
  - If set and clear coincide, set wins.
- Edge cases:
  - All channels muted: output 0, no saturation.
  - N_CH=2: adder tree degenerates to a single add.
  - OUT_W==SUM_W with avg_en=0: saturation is never triggered.
- Reset mid-operation: asynchronously discards all in-flight samples, and out_valid drops immediately.

Decomposition:
- Shared package mixer_pkg: SUM_W computation function, sat_clip function (signed value, target width -> clipped value plus clip bit), and min/max constant helpers. Reuse these in later formatter blocks.
- One natural sub-module: mixer_adder_tree, a combinational, parametrised signed summation of N_CH SUM_W operands. It keeps the top level to the pipeline/handshake plus the saturation logic.

Test Plan (all with N_CH=4, IN_W=8, OUT_W=9):
- Basic sum: ch = {100, 50, -20, 7}, mute=0, avg_en=0, out_ready=1 -> out_data=137 two cycles after accept; sat_flag stays 0.
- Saturation and clear:
  - All channels 127 -> out_data=255, sat_flag=1.
  - All channels -128 -> out_data=-256.
  - clr_sat pulsed on the same cycle as a new clipped sample -> sat_flag remains 1.
  - A lone clr_sat pulse afterwards -> sat_flag becomes 0.
- Average and mute:
  - {100, 50, -20, 7} with avg_en=1 -> 34.
  - {-1, 0, 0, 0} with avg_en=1 -> -1 (floor).
  - mute=4'b0011 on {100, 50, -20, 7} -> -13.
- Backpressure:
  - Stimulus: out_ready=0 for 6 cycles while in_valid is held high with samples 1..5 (channel 0 only).
  - Required: exactly 2 samples accepted, in_ready then low.
  - After out_ready=1: outputs 1, 2, 3, 4, 5 in order, back-to-back, with none lost.
- Streaming: 64 random samples, random out_ready -> output sequence matches the reference model, and throughput is 1/cycle whenever out_ready is held high.
- Reset mid-stream: assert rst_n low with both stages full -> out_valid=0 and out_data=0 immediately; after release, in_ready=1 and no stale sample ever appears.
